tacky_issue: RTL

- Instruction-issue controller for the TACKY core. It is the producer side of the 4-bit `Signal` channel and the 16-bit immediate that the PC `counter` consumes.
- Accepts one 16-bit instruction word per handshake. A word is either one 8-bit-immediate instruction or two packed 8-bit instructions.
- Sequences the packed slots and maintains the `pre` prefix byte.
- Drives the ALU opcode, register index and PC-write strobe, and halts on `sys`.

---
 rtl/tacky_defs.sv | 47 ++++
 rtl/tacky_slot_decode.sv | 74 +++++++
 rtl/tacky_issue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tacky_defs.sv
// Shared TACKY definitions: opcodes, Signal channel layout,
// control encodings, issue states and instruction-word fields.
package tacky_defs;

    // Signal channel bit positions: [1:0] J_8_Compare, [2] Reg_Value, [3] Jr_Load
    localparam int SIG_J8_LSB    = 0;
    localparam int SIG_REG_VALUE = 2;
    localparam int SIG_JR_LOAD   = 3;

    typedef logic [3:0] ctl_t;
    typedef logic [4:0] opc_t;

    localparam ctl_t CTL_NONE = 4'b0000;
    localparam ctl_t CTL_JZ   = ctl_t'(1) << SIG_J8_LSB;
    localparam ctl_t CTL_JNZ  = ctl_t'(2) << SIG_J8_LSB;
    localparam ctl_t CTL_JP   = ctl_t'(3) << SIG_J8_LSB;
    localparam ctl_t CTL_JR1  = ctl_t'(1) << SIG_JR_LOAD;
    localparam ctl_t CTL_JR2  = CTL_JR1 | (ctl_t'(1) << SIG_REG_VALUE);

    // Opcodes the issue logic treats specially
    localparam opc_t OP_JR     = 5'b01010;
    localparam opc_t OP_ILL_LO = 5'b10001;
    localparam opc_t OP_WIDE   = 5'b11000;
    localparam opc_t OP_JNZ8   = 5'b11001;
    localparam opc_t OP_JZ8    = 5'b11010;
    localparam opc_t OP_JP8    = 5'b11011;
    localparam opc_t OP_CF8    = 5'b11100;
    localparam opc_t OP_CI8    = 5'b11101;
    localparam opc_t OP_PRE    = 5'b11110;
    localparam opc_t OP_SYS    = 5'b11111;

    typedef enum logic [1:0] {
        ST_READY,
        ST_SLOT1,
        ST_SLOT2,
        ST_HALT
    } state_e;

    // Word fields; in the 8-bit format Imm8 = {opcode2, reg2}
    typedef struct packed {
        logic [4:0] opcode1;
        logic [2:0] reg1;
        logic [4:0] opcode2;
        logic [2:0] reg2;
    } word_t;

endpackage

// File: rtl/tacky_slot_decode.sv
// Per-slot opcode classifier for the TACKY issue controller.
// Purely combinational; slot2 selects second-slot rules.
module tacky_slot_decode
    import tacky_defs::*;
(
    input  logic [4:0] opcode,
    input  logic       slot2,
    output logic [3:0] control,
    output logic       op_valid,
    output logic       is_jr,
    output logic       is_sys,
    output logic       is_pre,
    output logic       uses_imm,
    output logic       illegal
);

    logic in_ill_range;
    logic hi_op;

    assign in_ill_range = (opcode >= OP_ILL_LO) && (opcode <= OP_WIDE);
    assign hi_op        = (opcode[4:3] == 2'b11);

    // Slot2 rejects every 11xxx except sys; both slots reject 10001..11000
    assign illegal = in_ill_range || (slot2 && hi_op && (opcode != OP_SYS));

    // Classify the opcode into its control/issue attributes
    always_comb begin
        control  = CTL_NONE;
        op_valid = 1'b0;
        is_jr    = 1'b0;
        is_sys   = 1'b0;
        is_pre   = 1'b0;
        uses_imm = 1'b0;
        unique case (1'b1)
            illegal: begin
                op_valid = 1'b0;
            end
            (opcode == OP_SYS): begin
                is_sys   = 1'b1;
                op_valid = 1'b1;
                uses_imm = !slot2;
            end
            (opcode == OP_JR): begin
                is_jr    = 1'b1;
                op_valid = 1'b1;
                control  = slot2 ? CTL_JR2 : CTL_JR1;
            end
            (opcode == OP_JZ8): begin
                control  = CTL_JZ;
                uses_imm = 1'b1;
            end
            (opcode == OP_JNZ8): begin
                control  = CTL_JNZ;
                uses_imm = 1'b1;
            end
            (opcode == OP_JP8): begin
                control  = CTL_JP;
                uses_imm = 1'b1;
            end
            (opcode == OP_CF8 || opcode == OP_CI8): begin
                op_valid = 1'b1;
                uses_imm = 1'b1;
            end
            (opcode == OP_PRE): begin
                is_pre   = 1'b1;
                uses_imm = 1'b1;
            end
            default: begin
                op_valid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tacky_issue.sv
// TACKY instruction-issue controller: accepts a word, issues its
// slot(s), manages the pre prefix byte and halts on sys.
module tacky_issue
    import tacky_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  control,
    output logic [15:0] immediate,
    output logic        pc_we,
    output logic [4:0]  op_out,
    output logic [2:0]  reg_out,
    output logic        op_valid,
    output logic        halted
);

    state_e     state_q, state_d;
    word_t      word_q, word_d;
    logic [7:0] pre_q, pre_d;
    logic       pre_valid_q, pre_valid_d;

    logic [4:0] dec_opcode;
    logic       dec_slot2;
    logic [3:0] dec_control;
    logic       dec_op_valid;
    logic       dec_is_jr;
    logic       dec_is_sys;
    logic       dec_is_pre;
    logic       dec_uses_imm;
    logic       dec_illegal;
    logic [7:0] imm8;
    logic       issue_ok;

    assign imm8       = {word_q.opcode2, word_q.reg2};
    assign dec_slot2  = (state_q == ST_SLOT2);
    assign dec_opcode = dec_slot2 ? word_q.opcode2 : word_q.opcode1;
    assign issue_ok   = dec_op_valid && !dec_illegal;

    tacky_slot_decode u_dec (
        .opcode   (dec_opcode),
        .slot2    (dec_slot2),
        .control  (dec_control),
        .op_valid (dec_op_valid),
        .is_jr    (dec_is_jr),
        .is_sys   (dec_is_sys),
        .is_pre   (dec_is_pre),
        .uses_imm (dec_uses_imm),
        .illegal  (dec_illegal)
    );

    // Next-state, prefix update and Moore outputs per slot
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        pre_d       = pre_q;
        pre_valid_d = pre_valid_q;
        instr_ready = 1'b0;
        control     = CTL_NONE;
        immediate   = 16'h0000;
        pc_we       = 1'b0;
        op_out      = 5'b00000;
        reg_out     = 3'b000;
        op_valid    = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            ST_READY: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    word_d  = instr;
                    state_d = ST_SLOT1;
                end
            end
            ST_SLOT1: begin
                op_out   = word_q.opcode1;
                reg_out  = word_q.reg1;
                control  = dec_control;
                op_valid = issue_ok;
                if (dec_uses_imm) begin
                    immediate = pre_valid_q ? {pre_q, imm8}
                                            : {{8{imm8[7]}}, imm8};
                    if (dec_is_pre) begin
                        pre_d       = imm8;
                        pre_valid_d = 1'b1;
                    end else if (!dec_is_sys) begin
                        pre_d       = 8'h00;
                        pre_valid_d = 1'b0;
                    end
                    if (dec_is_sys) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = ST_READY;
                    end
                end else if (dec_is_jr) begin
                    pc_we   = 1'b1;
                    state_d = ST_READY;
                end else if (dec_is_sys) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_SLOT2;
                end
            end
            ST_SLOT2: begin
                op_out   = word_q.opcode2;
                reg_out  = word_q.reg2;
                control  = dec_control;
                op_valid = issue_ok;
                if (dec_is_sys) begin
                    state_d = ST_HALT;
                end else begin
                    pc_we   = 1'b1;
                    state_d = ST_READY;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // State, latched word and prefix registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_READY;
            word_q      <= '0;
            pre_q       <= 8'h00;
            pre_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            pre_q       <= pre_d;
            pre_valid_q <= pre_valid_d;
        end
    end

endmodule
